// File: rtl/speicher_pkg.sv
// speicher_pkg: shared FSM state type and address constants for speicher_zugriff.
package speicher_pkg;
    localparam int ADR_W  = 32;
    localparam int IO_BIT = 31;
    typedef enum logic [1:0] {LEERLAUF, ZUGRIFF, WARTEN, FERTIG} zustand_t;
endpackage

// File: rtl/adress_dekoder.sv
// adress_dekoder: splits a core address into IO region and out-of-range RAM flags.
// The range check is built only with ADRESS_PRUEFUNG_EN defined; otherwise high bits wrap onto RAM.
module adress_dekoder
    import speicher_pkg::*;
#(
    parameter int A = 8
) (
    input  logic [ADR_W-1:0] adresse,
    output logic             io,
    output logic             ausser_bereich
);
    logic [IO_BIT-1:0] oben;
    assign io   = adresse[IO_BIT];
    assign oben = adresse[IO_BIT-1:0] >> A;
`ifdef ADRESS_PRUEFUNG_EN
    assign ausser_bereich = !io && |oben;
`else
    assign ausser_bereich = 1'b0 & |oben;
`endif
endmodule

// File: rtl/speicher_zugriff.sv
// speicher_zugriff: core-to-RAM access FSM with one memory-mapped output register.
// Optional address range checking is enabled by defining ADRESS_PRUEFUNG_EN.
module speicher_zugriff
    import speicher_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Schreiben,
    input  logic [ADR_W-1:0]          AdresseRein,
    input  logic [WORDSIZE-1:0]       DatenRein,
    output logic                      Bereit,
    output logic                      Fertig,
    output logic [WORDSIZE-1:0]       DatenRaus,
    output logic                      Fehler,
    output logic                      RamSchreibenAn,
    output logic [$clog2(WORDS)-1:0]  RamAdresse,
    output logic [WORDSIZE-1:0]       RamDatenRein,
    input  logic [WORDSIZE-1:0]       RamDatenRaus,
    output logic [WORDSIZE-1:0]       Ausgabe
);
    localparam int A = $clog2(WORDS);
    zustand_t          zustand;
    logic              schreiben_q;
    logic [A-1:0]      adresse_q;
    logic [WORDSIZE-1:0] daten_q;
    logic              io, ausser_bereich;

    adress_dekoder #(.A(A)) u_dekoder (
        .adresse        (AdresseRein),
        .io             (io),
        .ausser_bereich (ausser_bereich)
    );

    assign Bereit       = (zustand == LEERLAUF);
    assign RamAdresse   = adresse_q;
    assign RamDatenRein = daten_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand        <= LEERLAUF;
            schreiben_q    <= 1'b0;
            adresse_q      <= '0;
            daten_q        <= '0;
            Fertig         <= 1'b0;
            Fehler         <= 1'b0;
            RamSchreibenAn <= 1'b0;
            DatenRaus      <= '0;
            Ausgabe        <= '0;
        end else begin
            Fertig         <= 1'b0;
            Fehler         <= 1'b0;
            RamSchreibenAn <= 1'b0;
            case (zustand)
                LEERLAUF: if (Start) begin
                    schreiben_q <= Schreiben;
                    adresse_q   <= AdresseRein[A-1:0];
                    daten_q     <= DatenRein;
                    if (io) begin
                        zustand <= FERTIG;
                        Fertig  <= 1'b1;
                        if (Schreiben) Ausgabe <= DatenRein;
                        else DatenRaus <= Ausgabe;
                    end else if (ausser_bereich) begin
                        // rejected RAM request: no RAM cycle, a load returns zero
                        zustand <= FERTIG;
                        Fertig  <= 1'b1;
                        Fehler  <= 1'b1;
                        if (!Schreiben) DatenRaus <= '0;
                    end else begin
                        zustand        <= ZUGRIFF;
                        RamSchreibenAn <= Schreiben;
                    end
                end
                ZUGRIFF: begin
                    zustand <= schreiben_q ? FERTIG : WARTEN;
                    Fertig  <= schreiben_q;
                end
                WARTEN: begin
                    zustand   <= FERTIG;
                    Fertig    <= 1'b1;
                    DatenRaus <= RamDatenRaus;
                end
                default: zustand <= LEERLAUF;
            endcase
        end
    end
endmodule

// File: tb/tb_speicher_zugriff.sv
// tb_speicher_zugriff: randomized self-checking bench against a transaction-level reference model.
module tb_speicher_zugriff;
    localparam int W = 32;
    localparam int N = 256;

    logic          Clock = 0, Reset = 1, Start = 0, Schreiben = 0;
    logic [31:0]   AdresseRein = 0, DatenRein = 0;
    logic          Bereit, Fertig, Fehler, RamSchreibenAn;
    logic [W-1:0]  DatenRaus, RamDatenRein, Ausgabe;
    logic [W-1:0]  RamDatenRaus = 0;
    logic [7:0]    RamAdresse;

    logic [W-1:0]  mem [N] = '{default: '0};
    logic [W-1:0]  ref_ram [N] = '{default: '0};
    logic [W-1:0]  ref_aus = 0, ref_dr = 0;
    int            errors = 0, checks = 0;

    speicher_zugriff #(.WORDSIZE(W), .WORDS(N)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Schreiben(Schreiben),
        .AdresseRein(AdresseRein), .DatenRein(DatenRein), .Bereit(Bereit),
        .Fertig(Fertig), .DatenRaus(DatenRaus), .Fehler(Fehler),
        .RamSchreibenAn(RamSchreibenAn), .RamAdresse(RamAdresse),
        .RamDatenRein(RamDatenRein), .RamDatenRaus(RamDatenRaus), .Ausgabe(Ausgabe)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (RamSchreibenAn) mem[RamAdresse] <= RamDatenRein;
        else RamDatenRaus <= mem[RamAdresse];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [31:0] adr, input logic [31:0] d);
        int n, lat, wp, exp_lat, exp_wp;
        logic io, oor;
        n = 0;
        while (!Bereit && n < 10) begin
            @(negedge Clock);
            n++;
        end
        check("bereit_vor", Bereit, 1);
        io = adr[31];
`ifdef ADRESS_PRUEFUNG_EN
        oor = !io && (adr[30:8] != 0);
`else
        oor = 1'b0;
`endif
        exp_lat = (io || oor) ? 1 : (w ? 2 : 3);
        exp_wp  = (!io && !oor && w) ? 1 : 0;
        if (io) begin
            if (w) ref_aus = d;
            else ref_dr = ref_aus;
        end else if (oor) begin
            if (!w) ref_dr = 0;
        end else begin
            if (w) ref_ram[adr[7:0]] = d;
            else ref_dr = ref_ram[adr[7:0]];
        end
        Start = 1; Schreiben = w; AdresseRein = adr; DatenRein = d;
        @(posedge Clock);
        #1;
        Start = 0; DatenRein = $urandom; AdresseRein = $urandom;
        check("ausgabe_accept", Ausgabe, ref_aus);
        lat = 0; wp = 0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge Clock);
            if (c == 1) check("bereit_busy", Bereit, 0);
            if (RamSchreibenAn) begin
                wp++;
                check("ram_adr_wr", RamAdresse, adr[7:0]);
                check("ram_din", RamDatenRein, d);
            end
            if (!io && !oor && !w && c < 3) check("ram_adr_rd", RamAdresse, adr[7:0]);
            if (Fertig) begin
                lat = c;
                check("fehler", Fehler, oor);
            end
        end
        check("latenz", lat, exp_lat);
        check("schreibpulse", wp, exp_wp);
        check("datenraus", DatenRaus, ref_dr);
        check("ausgabe", Ausgabe, ref_aus);
    endtask

    initial begin
        int acc;
        logic [31:0] adr;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 0;
        check("rst_bereit", Bereit, 1);
        check("rst_fertig", Fertig, 0);
        check("rst_fehler", Fehler, 0);
        check("rst_we", RamSchreibenAn, 0);
        check("rst_dr", DatenRaus, 0);
        check("rst_aus", Ausgabe, 0);
        check("rst_ramadr", RamAdresse, 0);

        req(1, 32'h0000_0003, 32'h0000_0005);
        req(0, 32'h0000_0003, 32'h0);
        check("ram_load_5", DatenRaus, 32'h5);
        req(1, 32'h8000_0000, 32'h0000_00AB);
        req(0, 32'h8000_0004, 32'h0);
        check("io_load_ab", DatenRaus, 32'hAB);
        req(1, 32'h0000_0000, 32'h1234_5678);
        req(0, 32'h0000_0100, 32'h0);

        // Start held high with stores: accept every third cycle
        @(negedge Clock);
        while (!Bereit) @(negedge Clock);
        acc = 0;
        Start = 1; Schreiben = 1; AdresseRein = 32'h5; DatenRein = 32'hCAFE_0001;
        ref_ram[5] = 32'hCAFE_0001;
        for (int i = 0; i < 10; i++) begin
            check("dauer_bereit", Bereit, (i % 3) == 0);
            if (Bereit) acc++;
            @(negedge Clock);
        end
        Start = 0;
        check("dauer_accepts", acc, 4);
        repeat (3) @(negedge Clock);
        req(0, 32'h0000_0005, 32'h0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: adr = {1'b1, 31'($urandom)};
                3: adr = {1'b0, 31'($urandom)} | 32'h100;
                default: adr = {28'h0, 4'($urandom)};
            endcase
            req(1'($urandom), adr, $urandom);
        end

        // reset during a store's RAM cycle
        while (!Bereit) @(negedge Clock);
        Start = 1; Schreiben = 1; AdresseRein = 32'h7; DatenRein = 32'hDEAD_BEEF;
        @(posedge Clock);
        #1 Start = 0;
        check("abbruch_we_vor", RamSchreibenAn, 1);
        #1 Reset = 1;
        #1;
        check("abbruch_we", RamSchreibenAn, 0);
        check("abbruch_bereit", Bereit, 1);
        check("abbruch_dr", DatenRaus, 0);
        check("abbruch_aus", Ausgabe, 0);
        check("abbruch_fertig", Fertig, 0);
        ref_aus = 0; ref_dr = 0;
        @(negedge Clock);
        Reset = 0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (Fertig) acc++;
        end
        check("abbruch_kein_fertig", acc, 0);
        req(0, 32'h0000_0007, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
